// File: rtl/ysyx_220053_pkg.sv
// Shared fetch definitions: FSM state encoding and reset PC default.
// Also used by difftest glue to decode the fetch state.
package ysyx_220053_pkg;

  typedef enum logic [1:0] {
    FS_REQ  = 2'd0,
    FS_WAIT = 2'd1,
    FS_HOLD = 2'd2,
    FS_DROP = 2'd3
  } fetch_state_e;

  localparam logic [63:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;

  localparam logic [63:0] PC_STEP = 64'd4;

endpackage

// File: rtl/ysyx_220053_fetch_buf.sv
// Fetch output buffer: holds instruction, its pc and fault flag.
// Contents change only on load; cleared by synchronous reset.
module ysyx_220053_fetch_buf #(
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [INST_W-1:0] d_inst,
  input  logic [63:0]       d_pc,
  input  logic              d_err,
  output logic [INST_W-1:0] q_inst,
  output logic [63:0]       q_pc,
  output logic              q_err
);

  // capture a returned fetch; otherwise hold for decode
  always_ff @(posedge clk) begin
    if (!rst) begin
      q_inst <= '0;
      q_pc   <= '0;
      q_err  <= 1'b0;
    end else if (load) begin
      q_inst <= d_inst;
      q_pc   <= d_pc;
      q_err  <= d_err;
    end
  end

endmodule

// File: rtl/ysyx_220053_fetch_ctrl.sv
// Fetch sequencer: owns the fetch pc, one outstanding imem request,
// buffers the result for decode and applies EXU redirects.
module ysyx_220053_fetch_ctrl
  import ysyx_220053_pkg::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEF,
  parameter int          INST_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [63:0]       redirect_pc,
  output logic              imem_req_valid,
  output logic [63:0]       imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_data,
  input  logic              imem_resp_err,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [63:0]       inst_pc,
  output logic              inst_err,
  output logic [63:0]       pc
);

  fetch_state_e state;
  fetch_state_e state_n;
  logic [63:0]  pc_n;
  logic [63:0]  tgt;
  logic         load;

  assign tgt = redirect_pc & ~64'd3;

  assign imem_req_valid = (state == FS_REQ);
  assign imem_req_addr  = pc;
  assign inst_valid     = (state == FS_HOLD) && !redirect_valid;

  // state and pc registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= FS_REQ;
      pc    <= RESET_PC;
    end else begin
      state <= state_n;
      pc    <= pc_n;
    end
  end

  // next state, next pc and buffer load; redirect always wins
  always_comb begin
    state_n = state;
    pc_n    = pc;
    load    = 1'b0;
    case (state)
      FS_REQ: begin
        if (redirect_valid) begin
          pc_n = tgt;
          if (imem_req_ready) state_n = FS_DROP;
        end else if (imem_req_ready) begin
          state_n = FS_WAIT;
        end
      end
      FS_WAIT: begin
        if (imem_resp_valid && redirect_valid) begin
          pc_n    = tgt;
          state_n = FS_REQ;
        end else if (imem_resp_valid) begin
          load    = 1'b1;
          state_n = FS_HOLD;
        end else if (redirect_valid) begin
          pc_n    = tgt;
          state_n = FS_DROP;
        end
      end
      FS_HOLD: begin
        if (redirect_valid) begin
          pc_n    = tgt;
          state_n = FS_REQ;
        end else if (inst_ready) begin
          pc_n    = pc + PC_STEP;
          state_n = FS_REQ;
        end
      end
      FS_DROP: begin
        if (redirect_valid) pc_n = tgt;
        if (imem_resp_valid) state_n = FS_REQ;
      end
      default: state_n = FS_REQ;
    endcase
  end

  ysyx_220053_fetch_buf #(
    .INST_W(INST_W)
  ) u_buf (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .d_inst (imem_resp_data),
    .d_pc   (pc),
    .d_err  (imem_resp_err),
    .q_inst (inst),
    .q_pc   (inst_pc),
    .q_err  (inst_err)
  );

endmodule
